sram_responder: RTL

- Synthesizable on-chip emulation of the external asynchronous 10-bit SRAM device, i.e. the responder end of the SRAM pin interface (ce_n/we_n/oe_n/lb_n/ub_n/addr/dq).
- Replaces the external chip in FPGA builds and simulation, so the SRAM controller and the camera pipeline can run without the board part.
- Also provides access counters, a bus-contention flag and a backdoor read port for verification.

---
 rtl/sram_responder.sv | 111 +++++++++++
 1 files changed

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - on-chip emulation of the asynchronous 10-bit SRAM device
// Clears memory after reset, then services write/read pin cycles with counters and a contention flag.
module sram_responder #(
  parameter int             AW       = 8,
  parameter int             DW       = 10,
  parameter logic [DW-1:0]  INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce_n,
  input  logic          we_n,
  input  logic          oe_n,
  input  logic          lb_n,
  input  logic          ub_n,
  input  logic [AW-1:0] addr,
  inout  wire  [DW-1:0] sram_dq,
  output logic          ready,
  output logic          contention_err,
  output logic [15:0]   write_count,
  output logic [15:0]   read_count,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam int DEPTH = 2 ** AW;
  localparam int LW    = DW / 2;

  typedef enum logic [2:0] {CLEAR, IDLE, WR_ACTIVE, WR_COMMIT, RD_ACTIVE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_addr;
  logic [AW-1:0]   pend_addr;
  logic [DW-1:0]   pend_data;
  logic            pend_lb_n, pend_ub_n;
  logic [DW-1:0]   mem [DEPTH];
  logic            write_req, read_req;
  logic [DW-1:0]   rd_word, rd_drive;

  assign write_req = !ce_n && !we_n;
  assign read_req  = !ce_n && !oe_n && we_n;
  assign ready     = (state != CLEAR);

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:     if (&clr_addr) state_nxt = IDLE;
      IDLE: begin
        if (write_req)     state_nxt = WR_ACTIVE;
        else if (read_req) state_nxt = RD_ACTIVE;
      end
      WR_ACTIVE: if (!write_req) state_nxt = WR_COMMIT;
      WR_COMMIT: state_nxt = IDLE;
      RD_ACTIVE: if (!read_req) state_nxt = IDLE;
      default:   state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= CLEAR;
      clr_addr       <= '0;
      pend_addr      <= '0;
      pend_data      <= '0;
      pend_lb_n      <= 1'b1;
      pend_ub_n      <= 1'b1;
      write_count    <= '0;
      read_count     <= '0;
      contention_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR)
        clr_addr <= clr_addr + AW'(1);
      // Last low sample of the write strobe wins.
      if ((state == IDLE || state == WR_ACTIVE) && write_req) begin
        pend_addr <= addr;
        pend_data <= sram_dq;
        pend_lb_n <= lb_n;
        pend_ub_n <= ub_n;
      end
      if (state == WR_COMMIT && write_count != 16'hFFFF)
        write_count <= write_count + 16'd1;
      if (state == IDLE && !write_req && read_req && read_count != 16'hFFFF)
        read_count <= read_count + 16'd1;
      if (state != CLEAR && !ce_n && !we_n && !oe_n)
        contention_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_addr] <= INIT_VAL;
      end else if (state == WR_COMMIT) begin
        if (!pend_lb_n) mem[pend_addr][LW-1:0]  <= pend_data[LW-1:0];
        if (!pend_ub_n) mem[pend_addr][DW-1:LW] <= pend_data[DW-1:LW];
      end
    end
  end

  // Asynchronous array read so data is valid on the edge after oe_n falls.
  always_comb begin
    rd_word  = mem[addr];
    rd_drive = '0;
    if (!lb_n) rd_drive[LW-1:0]  = rd_word[LW-1:0];
    if (!ub_n) rd_drive[DW-1:LW] = rd_word[DW-1:LW];
  end

  assign sram_dq  = (ready && read_req) ? rd_drive : 'z;
  assign dbg_data = mem[dbg_addr];

endmodule
